fft_p_s_out: RTL and testbench

Parallel-to-serial output stage of the 16-point radix-4 FFT core. It captures the four 4-lane result groups that the second butterfly stage emits in the P_S_SEL_0..3 phases of the control sequence. It reorders them from digit-reversed to natural frequency order and streams one complex bin per cycle. Two 16-entry banks (ping-pong) let a new frame be captured while the previous one is still streaming.

---
 rtl/fft_p_s_out.sv | 228 ++++++++++++++++++++++
 tb/tb_fft_p_s_out.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_p_s_out.sv
// Parallel-to-serial output stage of the 16-point radix-4 FFT.
// Captures four 4-lane result groups into one of two 16-entry banks,
// reorders them from digit-reversed to natural order through the write
// addressing, and streams one complex bin per cycle from the filled bank.
module fft_p_s_out #(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [2:0]            demux_flag,
  input  logic [4*DATA_W-1:0]   in_re,
  input  logic [4*DATA_W-1:0]   in_im,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_re,
  output logic [DATA_W-1:0]     out_im,
  output logic [3:0]            out_idx,
  output logic                  out_last,
  output logic                  seq_err,
  output logic                  ovf_err
);

  typedef enum logic [0:0] {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } rd_state_t;

  // Bank storage, address = {bank, bin}; bank contents need no reset.
  logic [DATA_W-1:0] mem_re [0:31];
  logic [DATA_W-1:0] mem_im [0:31];

  // Writer state
  logic       wr_bank_r;
  logic [1:0] exp_grp_r;
  logic       wr_active_r;
  logic       drop_r;
  logic       wr_bank_nxt;
  logic [1:0] exp_grp_nxt;
  logic       wr_active_nxt;
  logic       drop_nxt;
  logic       seq_err_nxt;
  logic       ovf_err_nxt;
  logic       wr_en_s;
  logic       full_set_s;

  // Reader state
  rd_state_t  state_r;
  rd_state_t  state_nxt;
  logic [3:0] rd_cnt_r;
  logic [3:0] rd_cnt_nxt;
  logic       rd_bank_r;
  logic       rd_bank_nxt;
  logic       release_s;
  logic [1:0] full_r;
  logic [1:0] full_nxt;

  logic       accept_s;
  logic [1:0] grp_s;
  logic       bank_free_s;
  logic [4:0] rd_addr_s;

  assign accept_s  = in_valid && !demux_flag[2];
  assign grp_s     = demux_flag[1:0];
  assign rd_addr_s = {rd_bank_r, rd_cnt_r};
  // A bank being released by the reader on this edge counts as free.
  assign bank_free_s = !full_r[wr_bank_r] || (release_s && (rd_bank_r == wr_bank_r));

  // Reader next-state: stream 16 bins per full bank, chain banks without a bubble.
  always_comb begin
    state_nxt   = state_r;
    rd_cnt_nxt  = rd_cnt_r;
    rd_bank_nxt = rd_bank_r;
    release_s   = 1'b0;
    case (state_r)
      RD_IDLE: begin
        if (full_r[rd_bank_r]) begin
          state_nxt  = RD_STREAM;
          rd_cnt_nxt = 4'd0;
        end else begin
          state_nxt  = RD_IDLE;
        end
      end
      RD_STREAM: begin
        if (rd_cnt_r == 4'd15) begin
          release_s   = 1'b1;
          rd_bank_nxt = ~rd_bank_r;
          rd_cnt_nxt  = 4'd0;
          if (full_r[~rd_bank_r]) begin
            state_nxt = RD_STREAM;
          end else begin
            state_nxt = RD_IDLE;
          end
        end else begin
          rd_cnt_nxt = rd_cnt_r + 4'd1;
        end
      end
      default: begin
        state_nxt  = RD_IDLE;
        rd_cnt_nxt = 4'd0;
      end
    endcase
  end

  // Writer next-state: enforce group order 0..3 and bank availability.
  always_comb begin
    wr_bank_nxt   = wr_bank_r;
    exp_grp_nxt   = exp_grp_r;
    wr_active_nxt = wr_active_r;
    drop_nxt      = drop_r;
    seq_err_nxt   = seq_err;
    ovf_err_nxt   = ovf_err;
    wr_en_s       = 1'b0;
    full_set_s    = 1'b0;
    if (accept_s) begin
      if (grp_s == 2'd0) begin
        // A group 0 in the middle of a frame is out of order, but still restarts.
        if (wr_active_r) begin
          seq_err_nxt = 1'b1;
        end else begin
          seq_err_nxt = seq_err;
        end
        if (bank_free_s) begin
          wr_en_s       = 1'b1;
          exp_grp_nxt   = 2'd1;
          wr_active_nxt = 1'b1;
          drop_nxt      = 1'b0;
        end else begin
          ovf_err_nxt   = 1'b1;
          exp_grp_nxt   = 2'd0;
          wr_active_nxt = 1'b0;
          drop_nxt      = 1'b1;
        end
      end else if (drop_r) begin
        // Remaining groups of a dropped frame are silently ignored.
        drop_nxt = 1'b1;
      end else if (wr_active_r && (grp_s == exp_grp_r)) begin
        wr_en_s = 1'b1;
        if (grp_s == 2'd3) begin
          full_set_s    = 1'b1;
          wr_bank_nxt   = ~wr_bank_r;
          wr_active_nxt = 1'b0;
          exp_grp_nxt   = 2'd0;
        end else begin
          exp_grp_nxt   = exp_grp_r + 2'd1;
        end
      end else begin
        seq_err_nxt   = 1'b1;
        wr_active_nxt = 1'b0;
        exp_grp_nxt   = 2'd0;
      end
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Full flags: writer sets on group 3, reader clears on the last bin.
  always_comb begin
    full_nxt = full_r;
    if (release_s) begin
      full_nxt = full_nxt & ~(2'b01 << rd_bank_r);
    end else begin
      full_nxt = full_nxt;
    end
    if (full_set_s) begin
      full_nxt = full_nxt | (2'b01 << wr_bank_r);
    end else begin
      full_nxt = full_nxt;
    end
  end

  // Bank write: lane l of group g is bin 4*l+g, stored at address {bank, l, g}.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int l = 0; l < 4; l++) begin
        mem_re[{wr_bank_r, 2'(l), grp_s}] <= in_re[l*DATA_W +: DATA_W];
        mem_im[{wr_bank_r, 2'(l), grp_s}] <= in_im[l*DATA_W +: DATA_W];
      end
    end
  end

  // Control state registers for writer, reader and bank flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_r   <= 1'b0;
      exp_grp_r   <= 2'd0;
      wr_active_r <= 1'b0;
      drop_r      <= 1'b0;
      seq_err     <= 1'b0;
      ovf_err     <= 1'b0;
      state_r     <= RD_IDLE;
      rd_cnt_r    <= 4'd0;
      rd_bank_r   <= 1'b0;
      full_r      <= 2'b00;
    end else begin
      wr_bank_r   <= wr_bank_nxt;
      exp_grp_r   <= exp_grp_nxt;
      wr_active_r <= wr_active_nxt;
      drop_r      <= drop_nxt;
      seq_err     <= seq_err_nxt;
      ovf_err     <= ovf_err_nxt;
      state_r     <= state_nxt;
      rd_cnt_r    <= rd_cnt_nxt;
      rd_bank_r   <= rd_bank_nxt;
      full_r      <= full_nxt;
    end
  end

  // Registered output bin, valid while the reader is streaming.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_re    <= {DATA_W{1'b0}};
      out_im    <= {DATA_W{1'b0}};
      out_idx   <= 4'd0;
      out_last  <= 1'b0;
    end else if (state_r == RD_STREAM) begin
      out_valid <= 1'b1;
      out_re    <= mem_re[rd_addr_s];
      out_im    <= mem_im[rd_addr_s];
      out_idx   <= rd_cnt_r;
      out_last  <= (rd_cnt_r == 4'd15);
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_p_s_out.sv
// Self-checking bench for fft_p_s_out: table-driven write sequences with a
// scoreboard of expected bins, plus hand-written reset/latency sequences.
module tb_fft_p_s_out;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic [2:0]     demux_flag;
  logic [4*W-1:0] in_re;
  logic [4*W-1:0] in_im;
  logic           out_valid;
  logic [W-1:0]   out_re;
  logic [W-1:0]   out_im;
  logic [3:0]     out_idx;
  logic           out_last;
  logic           seq_err;
  logic           ovf_err;

  fft_p_s_out #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .demux_flag(demux_flag),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid), .out_re(out_re),
    .out_im(out_im), .out_idx(out_idx), .out_last(out_last),
    .seq_err(seq_err), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nvalid = 0;
  int first_v = 0;
  int last_v = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic [3:0]   idx;
    logic         last;
  } bin_t;
  bin_t sb[$];

  typedef struct {
    logic       vld;
    logic [2:0] flag;
    int         base;
    logic       push;
    logic       exp_seq;
    logic       exp_ovf;
  } op_t;
  op_t ops[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  // Output monitor: every valid bin is compared to the head of the scoreboard.
  always @(negedge clk) begin : mon
    bin_t e;
    if (!rst && out_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_bin: got idx=%0d re=%0d, required no output", out_idx, $signed(out_re));
      end else begin
        e = sb.pop_front();
        if ({out_re, out_im, out_idx, out_last} !== e) begin
          errors++;
          $display("FAIL bin: got re=%0d im=%0d idx=%0d last=%0d, required re=%0d im=%0d idx=%0d last=%0d",
                   $signed(out_re), $signed(out_im), out_idx, out_last,
                   $signed(e.re), $signed(e.im), e.idx, e.last);
        end
      end
      if (nvalid == 0) first_v = cyc;
      last_v = cyc;
      nvalid++;
    end
  end

  task automatic push_frame(int base);
    bin_t e;
    for (int k = 0; k < 16; k++) begin
      e.re   = 16'(base + k);
      e.im   = 16'(-(base + k));
      e.idx  = 4'(k);
      e.last = (k == 15);
      sb.push_back(e);
    end
  endtask

  function automatic op_t mk(logic vld, logic [2:0] flag, int base, logic push, logic es, logic eo);
    op_t o;
    o.vld = vld; o.flag = flag; o.base = base; o.push = push; o.exp_seq = es; o.exp_ovf = eo;
    return o;
  endfunction

  task automatic add_frame(int base, logic push, logic es, logic eo);
    for (int g = 0; g < 4; g++) ops.push_back(mk(1'b1, 3'(g), base, push && (g == 3), es, eo));
  endtask

  task automatic add_idle(int n, logic es, logic eo);
    for (int i = 0; i < n; i++) ops.push_back(mk(1'b0, 3'b000, 0, 1'b0, es, eo));
  endtask

  // Lane l of group g carries bin 4*l+g: re = base+k, im = -(base+k).
  task automatic drive(logic vld, logic [2:0] flag, int base);
    int g;
    g = int'(flag[1:0]);
    in_valid   = vld;
    demux_flag = flag;
    for (int l = 0; l < 4; l++) begin
      in_re[l*W +: W] = W'(base + 4*l + g);
      in_im[l*W +: W] = W'(-(base + 4*l + g));
    end
  endtask

  task automatic run_ops();
    foreach (ops[i]) begin
      drive(ops[i].vld, ops[i].flag, ops[i].base);
      if (ops[i].push) push_frame(ops[i].base);
      @(posedge clk); #1;
      chk("seq_err", seq_err, ops[i].exp_seq);
      chk("ovf_err", ovf_err, ops[i].exp_ovf);
    end
    in_valid = 1'b0;
    ops.delete();
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    repeat (6) @(posedge clk);
    #1;
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic rst_dut();
    rst = 1'b1;
    drive(1'b0, 3'b000, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    nvalid = 0; first_v = 0; last_v = 0;
  endtask

  int e_cyc;
  bit found;

  initial begin
    rst = 1'b1;
    drive(1'b0, 3'b000, 0);
    in_re = '0; in_im = '0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_re", out_re, 0);
    chk("rst_out_im", out_im, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_seq_err", seq_err, 0);
    chk("rst_ovf_err", ovf_err, 0);
    rst = 1'b0;

    // Single frame, bin k = (k, -k); latency from group 3 edge
    add_frame(0, 1'b1, 1'b0, 1'b0);
    run_ops();
    e_cyc = cyc;
    drain();
    chk("single_first_cycle", first_v, e_cyc + 2);
    chk("single_last_cycle", last_v, e_cyc + 17);
    chk("single_count", nvalid, 16);

    // Two frames, group 3 writes 16 apart, REG_SEL and idle-flag noise
    rst_dut();
    add_frame(32, 1'b1, 1'b0, 1'b0);
    add_idle(4, 1'b0, 1'b0);
    ops.push_back(mk(1'b0, 3'b010, 777, 1'b0, 1'b0, 1'b0));
    ops.push_back(mk(1'b1, 3'b101, 888, 1'b0, 1'b0, 1'b0));
    add_idle(4, 1'b0, 1'b0);
    ops.push_back(mk(1'b1, 3'b000, 200, 1'b0, 1'b0, 1'b0));
    ops.push_back(mk(1'b1, 3'b100, 999, 1'b0, 1'b0, 1'b0));
    ops.push_back(mk(1'b1, 3'b001, 200, 1'b0, 1'b0, 1'b0));
    ops.push_back(mk(1'b1, 3'b010, 200, 1'b0, 1'b0, 1'b0));
    ops.push_back(mk(1'b1, 3'b111, 999, 1'b0, 1'b0, 1'b0));
    ops.push_back(mk(1'b1, 3'b011, 200, 1'b1, 1'b0, 1'b0));
    run_ops();
    drain();
    chk("b2b_count", nvalid, 32);
    chk("b2b_contiguous", last_v - first_v + 1, 32);

    // Three frames 8 apart: the third is dropped with ovf_err
    rst_dut();
    add_frame(0, 1'b1, 1'b0, 1'b0);
    add_idle(4, 1'b0, 1'b0);
    add_frame(64, 1'b1, 1'b0, 1'b0);
    add_idle(4, 1'b0, 1'b0);
    add_frame(128, 1'b0, 1'b0, 1'b1);
    run_ops();
    drain();
    repeat (10) @(posedge clk);
    #1;
    chk("ovf_count", nvalid, 32);
    chk("ovf_sticky", ovf_err, 1);
    chk("ovf_no_seq", seq_err, 0);

    // Out-of-order groups 0,2 then a clean frame
    rst_dut();
    ops.push_back(mk(1'b1, 3'b000, 50, 1'b0, 1'b0, 1'b0));
    ops.push_back(mk(1'b1, 3'b010, 50, 1'b0, 1'b1, 1'b0));
    add_frame(60, 1'b1, 1'b1, 1'b0);
    run_ops();
    drain();
    chk("seq_count", nvalid, 16);

    // Reset in the middle of a stream
    rst_dut();
    add_frame(300, 1'b1, 1'b0, 1'b0);
    run_ops();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (out_valid && out_idx == 4'd7) found = 1'b1;
    end
    chk("mid_rst_reached_bin7", found, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_re", out_re, 0);
    chk("mid_rst_idx", out_idx, 0);
    chk("mid_rst_last", out_last, 0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("mid_rst_aborted", sb.size(), 0);
    nvalid = 0;
    add_frame(500, 1'b1, 1'b0, 1'b0);
    run_ops();
    drain();
    chk("post_rst_count", nvalid, 16);
    chk("post_rst_seq", seq_err, 0);
    chk("post_rst_ovf", ovf_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
